// File: rtl/branch_resolve_unit_if.sv
// Fetch/resolve/BTB-update signal bundle for branch_resolve_unit.
// The slave modport is the unit's view; master is the surrounding pipeline's.
interface branch_resolve_unit_if #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_W     = 16
);
    logic                 PredPush;
    logic [WORD_SIZE-1:0] PredPC;
    logic                 PredValid;
    logic [WORD_SIZE-1:0] PredTarget;
    logic                 ResolveValid;
    logic                 ResolveIsBranch;
    logic                 ResolveTaken;
    logic [WORD_SIZE-1:0] ResolveTarget;
    logic                 Flush;
    logic [WORD_SIZE-1:0] RedirectPC;
    logic                 UpdateEn;
    logic                 UpdateTaken;
    logic [WORD_SIZE-1:0] UpdatePC;
    logic [WORD_SIZE-1:0] UpdateTarget;
    logic                 Full;
    logic                 Empty;
    logic                 Overflow;
    logic [CNT_W-1:0]     ResolvedCnt;
    logic [CNT_W-1:0]     MispredCnt;

    modport master (
        output PredPush, PredPC, PredValid, PredTarget,
        output ResolveValid, ResolveIsBranch, ResolveTaken, ResolveTarget,
        input  Flush, RedirectPC, UpdateEn, UpdateTaken, UpdatePC, UpdateTarget,
        input  Full, Empty, Overflow, ResolvedCnt, MispredCnt
    );

    modport slave (
        input  PredPush, PredPC, PredValid, PredTarget,
        input  ResolveValid, ResolveIsBranch, ResolveTaken, ResolveTarget,
        output Flush, RedirectPC, UpdateEn, UpdateTaken, UpdatePC, UpdateTarget,
        output Full, Empty, Overflow, ResolvedCnt, MispredCnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order prediction queue that checks execute results against BTB predictions,
// issuing flush/redirect and BTB training updates. Statistics counters: BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    branch_resolve_unit_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] QFULL = (PTR_W+1)'(DEPTH);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    state_t               stateReg;
    logic [WORD_SIZE-1:0] pcMem     [DEPTH];
    logic                 validMem  [DEPTH];
    logic [WORD_SIZE-1:0] targetMem [DEPTH];
    logic [PTR_W-1:0]     headPtr;
    logic [PTR_W-1:0]     tailPtr;
    logic [PTR_W:0]       countReg;

    logic                 isFull, isEmpty;
    logic                 popAccept, pushAccept, pushDropped;
    logic                 takenBranch, mispredict, updateHit;
    logic [WORD_SIZE-1:0] headPC, headTarget, pcPlusOne, predNext, actualNext;
    logic                 headValid;

    assign isFull    = (countReg == QFULL);
    assign isEmpty   = (countReg == '0);
    assign bus.Full  = isFull;
    assign bus.Empty = isEmpty;

    always_comb begin
        headPC      = pcMem[headPtr];
        headValid   = validMem[headPtr];
        headTarget  = targetMem[headPtr];
        pcPlusOne   = headPC + WORD_SIZE'(1);
        takenBranch = bus.ResolveIsBranch & bus.ResolveTaken;
        predNext    = headValid ? headTarget : pcPlusOne;
        actualNext  = takenBranch ? bus.ResolveTarget : pcPlusOne;
        popAccept   = (stateReg == RUN) & bus.ResolveValid & ~isEmpty;
        // A pop in the same cycle frees a slot, so a push while Full still lands.
        pushAccept  = (stateReg == RUN) & bus.PredPush & (~isFull | popAccept);
        pushDropped = (stateReg == RUN) & bus.PredPush & isFull & ~popAccept;
        mispredict  = popAccept & (predNext != actualNext);
        updateHit   = popAccept & (bus.ResolveIsBranch | headValid);
    end

    always_ff @(posedge Clk) begin
        if (pushAccept) begin
            pcMem[tailPtr]     <= bus.PredPC;
            validMem[tailPtr]  <= bus.PredValid;
            targetMem[tailPtr] <= bus.PredTarget;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateReg         <= RUN;
            headPtr          <= '0;
            tailPtr          <= '0;
            countReg         <= '0;
            bus.Overflow     <= 1'b0;
            bus.Flush        <= 1'b0;
            bus.RedirectPC   <= '0;
            bus.UpdateEn     <= 1'b0;
            bus.UpdateTaken  <= 1'b0;
            bus.UpdatePC     <= '0;
            bus.UpdateTarget <= '0;
        end else begin
            bus.Flush        <= 1'b0;
            bus.RedirectPC   <= '0;
            bus.UpdateEn     <= 1'b0;
            bus.UpdateTaken  <= 1'b0;
            bus.UpdatePC     <= '0;
            bus.UpdateTarget <= '0;
            case (stateReg)
                RUN: begin
                    if (pushAccept) tailPtr <= tailPtr + PTR_W'(1);
                    if (popAccept)  headPtr <= headPtr + PTR_W'(1);
                    case ({pushAccept, popAccept})
                        2'b10:   countReg <= countReg + (PTR_W+1)'(1);
                        2'b01:   countReg <= countReg - (PTR_W+1)'(1);
                        default: countReg <= countReg;
                    endcase
                    if (pushDropped) bus.Overflow <= 1'b1;
                    bus.Flush        <= mispredict;
                    bus.RedirectPC   <= mispredict ? actualNext : '0;
                    bus.UpdateEn     <= updateHit;
                    bus.UpdateTaken  <= updateHit & takenBranch;
                    bus.UpdatePC     <= updateHit ? headPC : '0;
                    bus.UpdateTarget <= updateHit ? actualNext : '0;
                    if (mispredict) stateReg <= FLUSH;
                end
                default: begin
                    // Everything still queued is younger than the mispredict: drop it.
                    headPtr  <= '0;
                    tailPtr  <= '0;
                    countReg <= '0;
                    stateReg <= RUN;
                end
            endcase
        end
    end

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] resolvedCntReg, mispredCntReg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            resolvedCntReg <= '0;
            mispredCntReg  <= '0;
        end else begin
            if (popAccept && resolvedCntReg != '1)
                resolvedCntReg <= resolvedCntReg + CNT_W'(1);
            if (mispredict && mispredCntReg != '1)
                mispredCntReg <= mispredCntReg + CNT_W'(1);
        end
    end

    assign bus.ResolvedCnt = resolvedCntReg;
    assign bus.MispredCnt  = mispredCntReg;
`else
    assign bus.ResolvedCnt = {CNT_W{1'b0}};
    assign bus.MispredCnt  = {CNT_W{1'b0}};
`endif
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolution-side partner of the branch target buffer. It holds the fetch-stage prediction for every in-flight instruction in a small in-order queue. When the execute stage resolves the instruction, the unit compares the real next PC with the predicted one and produces a one-cycle flush plus redirect PC on a mismatch. It also produces the registered BTB update stream (taken flag, index PC, real target) that trains the predictor.

## Interface
- `WORD_SIZE`, default 16: PC and target width.
- `DEPTH`, default 4: in-flight prediction queue entries; must be a power of two, 2 to 16.
- `CNT_W`, default 16: width of the statistics counters.

- `Clk`  in  1: single clock; all state changes on the rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `PredPush`  in  1: fetch pushes one prediction this cycle.
- `PredPC`  in  WORD_SIZE: PC of the fetched instruction.
- `PredValid`  in  1: the BTB hit and predicted taken (the BTB's Valid).
- `PredTarget`  in  WORD_SIZE: BTB predicted PC; meaningful only when PredValid=1.
- `ResolveValid`  in  1: execute resolves the oldest in-flight instruction.
- `ResolveIsBranch`  in  1: the resolved instruction is a branch or jump.
- `ResolveTaken`  in  1: the branch was actually taken.
- `ResolveTarget`  in  WORD_SIZE: actual taken target.
- `Flush`  out  1: one-cycle pulse; squash younger instructions.
- `RedirectPC`  out  WORD_SIZE: correct next PC; valid while Flush=1.
- `UpdateEn`  out  1: BTB write strobe.
- `UpdateTaken`  out  1: drives the BTB isTaken input.
- `UpdatePC`  out  WORD_SIZE: drives the BTB targetPC (index/tag) input; equals the resolved instruction's PC.
- `UpdateTarget`  out  WORD_SIZE: drives the BTB realPC input.
- `Full`, `Empty`  out  1 each: queue status; combinational from the registered count.
- `Overflow`  out  1: sticky; set when a push is dropped.
- `ResolvedCnt`, `MispredCnt`  out  CNT_W each: statistics counters.

## Operation
- The queue stores {PredPC, PredValid, PredTarget} in push order. The resolve port always consumes the head entry.
- Predicted next PC = PredValid ? PredTarget : PredPC+1. Arithmetic is modulo 2^WORD_SIZE; 0xFFFF+1 wraps to 0x0000.
- Actual next PC = (ResolveIsBranch & ResolveTaken) ? ResolveTarget : PredPC+1.
- Mispredict = ResolveValid & !Empty & (predicted ≠ actual).
  - A non-branch that was predicted taken is a mispredict (tag alias).
- BTB update is issued when a resolve hits a branch, or hits a non-branch with PredValid=1.
  - UpdateTaken = ResolveIsBranch & ResolveTaken.
  - UpdatePC = PredPC.
  - UpdateTarget = actual next PC.
- The FSM has two states:
  - RUN: normal push/pop. Push and pop in the same cycle are allowed, including when Full.
  - RUN → FLUSH on a mispredict.
  - FLUSH: lasts exactly one cycle. The queue is cleared at the end of the cycle, and all PredPush and ResolveValid inputs are ignored. Always FLUSH → RUN.
- Boundary cases:
  - ResolveValid while Empty: ignored; no update, no flush, counters unchanged.
  - PredPush while Full with no pop: push dropped, Overflow←1. Overflow clears only on Reset.
  - A pop and a push in the mispredict cycle both complete. The queue is cleared in the following FLUSH cycle regardless.
- Reset, including mid-operation: queue empty, state RUN, and Flush, RedirectPC, UpdateEn, UpdateTaken, UpdatePC, UpdateTarget, Overflow, ResolvedCnt, MispredCnt all 0. Empty=1, Full=0.

## Timing
- Resolve in cycle N → Flush, RedirectPC and Update* are registered and visible in cycle N+1 for exactly one cycle.
- Flush is high only in the FLUSH state cycle. Back-to-back Flush pulses are impossible.
- A prediction pushed in cycle N can be resolved in cycle N+1 at the earliest.
- Full and Empty reflect the count after the previous edge.
- Throughput: one push and one resolve per cycle in RUN.

## Configuration
- `BRU_STATS_EN` defined:
  - ResolvedCnt increments on every accepted resolve.
  - MispredCnt increments on every mispredict.
  - Both saturate at 2^CNT_W−1 and are cleared by Reset.
- `BRU_STATS_EN` undefined: no counter registers are built, and both outputs are tied to 0.

## Test plan
- Push PC=0x0010, PredValid=0; resolve IsBranch=0. Required next cycle: Flush=0, UpdateEn=0, Empty=1.
- Push PC=0x0020, PredValid=1, Target=0x0040; resolve IsBranch=1, Taken=1, Target=0x0040. Required next cycle: Flush=0, UpdateEn=1, UpdateTaken=1, UpdatePC=0x0020, UpdateTarget=0x0040.
- Push PC=0x0030, PredValid=1, Target=0x0050; resolve IsBranch=1, Taken=0. Required next cycle: Flush=1, RedirectPC=0x0031, UpdateTaken=0. Queue is Empty after FLUSH, and a push during FLUSH is ignored.
- Push DEPTH entries, then push again with no pop. Required: Full=1, Overflow=1, count stays DEPTH. Then push+pop together: count stays DEPTH, Overflow stays 1.
- Push PC=0xFFFF, PredValid=0; resolve IsBranch=1, Taken=0. Required: no flush; UpdateTarget=0x0000 (wrap).
- Assert Reset with 3 entries queued and a Flush pending. Required next cycle: all outputs 0, Empty=1. With BRU_STATS_EN: counters 0 after reset, and MispredCnt=1 after the mispredict scenario.
